// File: rtl/control_sequencer.sv
// Microcoded-style control sequencer: fetches via T0..T2, then decodes ir into
// per-class bus/enable strobes for T3..T6. Illegal opcodes park the FSM in HALT.
//
// state  | meaning
// IDLE   | waiting for run
// T0     | PC -> MAR, start PC increment into Z
// T1     | Z -> PC, memory read into MDR
// T2     | MDR -> IR
// T3..T6 | class-dependent execute steps, last one pulses done
// HALT   | illegal opcode seen, only clr leaves
module control_sequencer (
   input  logic        clk,
   input  logic        clr,
   input  logic        run,
   input  logic [31:0] ir,
   output logic        pc_out,
   output logic        zlo_out,
   output logic        zhi_out,
   output logic        mdr_out,
   output logic        c_out,
   output logic        mar_enable,
   output logic        z_enable,
   output logic        y_enable,
   output logic        ir_enable,
   output logic        pc_enable,
   output logic        mdr_enable,
   output logic        lo_enable,
   output logic        hi_enable,
   output logic        read,
   output logic        pc_increment,
   output logic [4:0]  op_code,
   output logic [15:0] r_out,
   output logic [15:0] r_enable,
   output logic        done,
   output logic        halted
);

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
   } state_t;

   state_t state, state_nx;

   logic [4:0] opcode;
   logic [3:0] ra, rb, rc;
   logic       is_rr, is_imm, is_unary, is_muldiv, is_legal;
   logic       unused_ir_bits;

   assign opcode         = ir[31:27];
   assign ra             = ir[26:23];
   assign rb             = ir[22:19];
   assign rc             = ir[18:15];
   assign unused_ir_bits = ^ir[14:0];

   assign is_rr     = (opcode >= 5'd3) && (opcode <= 5'd11);
   assign is_imm    = (opcode >= 5'd12) && (opcode <= 5'd14);
   assign is_muldiv = (opcode == 5'd15) || (opcode == 5'd16);
   assign is_unary  = (opcode == 5'd17) || (opcode == 5'd18);
   assign is_legal  = is_rr || is_imm || is_muldiv || is_unary;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) state <= S_IDLE;
      else     state <= state_nx;
   end

   // run is only looked at in IDLE and in the done step of each class
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: state_nx = run ? S_T0 : S_IDLE;
         S_T0:   state_nx = S_T1;
         S_T1:   state_nx = S_T2;
         S_T2:   state_nx = S_T3;
         S_T3:   state_nx = is_legal ? S_T4 : S_HALT;
         S_T4:   state_nx = is_unary ? (run ? S_T0 : S_IDLE) : S_T5;
         S_T5:   state_nx = is_muldiv ? S_T6 : (run ? S_T0 : S_IDLE);
         S_T6:   state_nx = run ? S_T0 : S_IDLE;
         S_HALT: state_nx = S_HALT;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      pc_out       = 1'b0;
      zlo_out      = 1'b0;
      zhi_out      = 1'b0;
      mdr_out      = 1'b0;
      c_out        = 1'b0;
      mar_enable   = 1'b0;
      z_enable     = 1'b0;
      y_enable     = 1'b0;
      ir_enable    = 1'b0;
      pc_enable    = 1'b0;
      mdr_enable   = 1'b0;
      lo_enable    = 1'b0;
      hi_enable    = 1'b0;
      read         = 1'b0;
      pc_increment = 1'b0;
      op_code      = 5'd0;
      r_out        = 16'd0;
      r_enable     = 16'd0;
      done         = 1'b0;
      halted       = 1'b0;
      case (state)
         S_T0: begin
            pc_out       = 1'b1;
            mar_enable   = 1'b1;
            pc_increment = 1'b1;
            z_enable     = 1'b1;
         end
         S_T1: begin
            zlo_out    = 1'b1;
            pc_enable  = 1'b1;
            read       = 1'b1;
            mdr_enable = 1'b1;
         end
         S_T2: begin
            mdr_out   = 1'b1;
            ir_enable = 1'b1;
         end
         S_T3: begin
            if (is_rr || is_imm) begin
               r_out    = 16'b1 << rb;
               y_enable = 1'b1;
            end else if (is_unary) begin
               r_out    = 16'b1 << rb;
               op_code  = opcode;
               z_enable = 1'b1;
            end else if (is_muldiv) begin
               r_out    = 16'b1 << ra;
               y_enable = 1'b1;
            end
         end
         S_T4: begin
            if (is_rr || is_imm) begin
               if (is_imm) c_out = 1'b1;
               else        r_out = 16'b1 << rc;
               op_code  = opcode;
               z_enable = 1'b1;
            end else if (is_unary) begin
               zlo_out  = 1'b1;
               r_enable = 16'b1 << ra;
               done     = 1'b1;
            end else begin
               r_out    = 16'b1 << rb;
               op_code  = opcode;
               z_enable = 1'b1;
            end
         end
         S_T5: begin
            zlo_out = 1'b1;
            if (is_muldiv) begin
               lo_enable = 1'b1;
            end else begin
               r_enable = 16'b1 << ra;
               done     = 1'b1;
            end
         end
         S_T6: begin
            zhi_out   = 1'b1;
            hi_enable = 1'b1;
            done      = 1'b1;
         end
         S_HALT: halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed vectors plus random instruction streams
// checked cycle by cycle against a per-class micro-step table.
module tb_control_sequencer;

   typedef struct packed {
      logic        pc_out, zlo_out, zhi_out, mdr_out, c_out;
      logic        mar_enable, z_enable, y_enable, ir_enable, pc_enable;
      logic        mdr_enable, lo_enable, hi_enable, read, pc_increment;
      logic [4:0]  op_code;
      logic [15:0] r_out, r_enable;
      logic        done, halted;
   } out_t;

   logic        clk, clr, run;
   logic [31:0] ir;
   logic        pc_out, zlo_out, zhi_out, mdr_out, c_out;
   logic        mar_enable, z_enable, y_enable, ir_enable, pc_enable;
   logic        mdr_enable, lo_enable, hi_enable, read, pc_increment;
   logic [4:0]  op_code;
   logic [15:0] r_out, r_enable;
   logic        done, halted;
   out_t        got;

   int n_checks = 0;
   int n_pass   = 0;

   control_sequencer dut (
      .clk(clk), .clr(clr), .run(run), .ir(ir),
      .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out), .mdr_out(mdr_out),
      .c_out(c_out), .mar_enable(mar_enable), .z_enable(z_enable),
      .y_enable(y_enable), .ir_enable(ir_enable), .pc_enable(pc_enable),
      .mdr_enable(mdr_enable), .lo_enable(lo_enable), .hi_enable(hi_enable),
      .read(read), .pc_increment(pc_increment), .op_code(op_code),
      .r_out(r_out), .r_enable(r_enable), .done(done), .halted(halted)
   );

   assign got = {pc_out, zlo_out, zhi_out, mdr_out, c_out,
                 mar_enable, z_enable, y_enable, ir_enable, pc_enable,
                 mdr_enable, lo_enable, hi_enable, read, pc_increment,
                 op_code, r_out, r_enable, done, halted};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 0 illegal, 1 reg-reg, 2 immediate, 3 unary, 4 mul/div
   function automatic int op_class(input logic [4:0] opc);
      if (opc >= 3 && opc <= 11)  return 1;
      if (opc >= 12 && opc <= 14) return 2;
      if (opc == 17 || opc == 18) return 3;
      if (opc == 15 || opc == 16) return 4;
      return 0;
   endfunction

   function automatic int instr_len(input logic [31:0] w);
      case (op_class(w[31:27]))
         1, 2:    return 6;
         3:       return 5;
         4:       return 7;
         default: return 4;
      endcase
   endfunction

   // expected outputs at step k counted from T0 (k=0)
   function automatic out_t exp_step(input logic [31:0] w, input int k);
      out_t o;
      int   c;
      int   ra, rb, rc;
      o  = '0;
      c  = op_class(w[31:27]);
      ra = int'(w[26:23]);
      rb = int'(w[22:19]);
      rc = int'(w[18:15]);
      if (k == 0) begin
         o.pc_out = 1; o.mar_enable = 1; o.pc_increment = 1; o.z_enable = 1;
      end else if (k == 1) begin
         o.zlo_out = 1; o.pc_enable = 1; o.read = 1; o.mdr_enable = 1;
      end else if (k == 2) begin
         o.mdr_out = 1; o.ir_enable = 1;
      end else if (c == 0) begin
         if (k >= 4) o.halted = 1;
      end else if (c == 3) begin
         if (k == 3) begin
            o.r_out[rb] = 1; o.op_code = w[31:27]; o.z_enable = 1;
         end else if (k == 4) begin
            o.zlo_out = 1; o.r_enable[ra] = 1; o.done = 1;
         end
      end else if (c == 4) begin
         if (k == 3)      begin o.r_out[ra] = 1; o.y_enable = 1; end
         else if (k == 4) begin o.r_out[rb] = 1; o.op_code = w[31:27]; o.z_enable = 1; end
         else if (k == 5) begin o.zlo_out = 1; o.lo_enable = 1; end
         else if (k == 6) begin o.zhi_out = 1; o.hi_enable = 1; o.done = 1; end
      end else begin
         if (k == 3) begin
            o.r_out[rb] = 1; o.y_enable = 1;
         end else if (k == 4) begin
            if (c == 2) o.c_out = 1;
            else        o.r_out[rc] = 1;
            o.op_code = w[31:27]; o.z_enable = 1;
         end else if (k == 5) begin
            o.zlo_out = 1; o.r_enable[ra] = 1; o.done = 1;
         end
      end
      return o;
   endfunction

   function automatic logic [31:0] rand_legal();
      logic [31:0] w;
      w = $urandom;
      w[31:27] = 5'($urandom_range(3, 18));
      return w;
   endfunction

   // Entered at a negedge with the DUT in T0; leaves it in T0 again.
   task automatic exec_instr(input logic [31:0] w, input logic run_after,
                             input logic toggle_run);
      out_t e;
      int   len;
      len = instr_len(w);
      for (int k = 0; k < len; k++) begin
         e = exp_step(w, k);
         n_checks++;
         if (got !== e)
            $display("FAIL instr ir=%h step=%0d got=%h expected=%h", w, k, got, e);
         else
            n_pass++;
         if (k < 2)       ir = $urandom;
         else if (k == 2) ir = w;
         if (k == len - 1) run = run_after;
         else              run = toggle_run ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk); @(negedge clk);
      end
      if (!run_after) begin
         n_checks++;
         if (got !== out_t'(0))
            $display("FAIL idle_after_done got=%h expected=0", got);
         else
            n_pass++;
         run = 1'b1;
         @(posedge clk); @(negedge clk);
      end
   endtask

   task automatic test_reset();
      clr = 1'b1; run = 1'b0; ir = 32'h0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (got !== out_t'(0)) $display("FAIL reset_outputs got=%h expected=0", got);
      else n_pass++;
      run = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (got !== out_t'(0)) $display("FAIL reset_run_held got=%h expected=0", got);
      else n_pass++;
      run = 1'b0;
      clr = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (got !== out_t'(0)) $display("FAIL idle_hold got=%h expected=0", got);
      else n_pass++;
      run = 1'b1;
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (got !== exp_step(32'h0, 0)) $display("FAIL idle_to_t0 got=%h expected=%h", got, exp_step(32'h0, 0));
      else n_pass++;
   endtask

   task automatic test_directed();
      exec_instr(32'h5091_8000, 1'b1, 1'b0);
      exec_instr(32'h7A28_0000, 1'b1, 1'b0);
      exec_instr(32'h6338_001F, 1'b1, 1'b0);
      exec_instr(32'h8918_0000, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      exec_instr(32'h5091_8000, 1'b1, 1'b0);
      exec_instr(32'h5091_8000, 1'b1, 1'b0);
      exec_instr(32'h0000_8000 | (32'd3 << 27), 1'b1, 1'b1);
   endtask

   task automatic test_clr_mid();
      logic [31:0] w;
      w = 32'h5091_8000;
      for (int k = 0; k < 4; k++) begin
         if (k == 2) ir = w;
         @(posedge clk); @(negedge clk);
      end
      n_checks++;
      if (got !== exp_step(w, 4)) $display("FAIL pre_clr_t4 got=%h expected=%h", got, exp_step(w, 4));
      else n_pass++;
      clr = 1'b1;
      #1;
      n_checks++;
      if (got !== out_t'(0)) $display("FAIL clr_async got=%h expected=0", got);
      else n_pass++;
      run = 1'b1;
      #1 clr = 1'b0;
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (got !== exp_step(w, 0)) $display("FAIL clr_release_t0 got=%h expected=%h", got, exp_step(w, 0));
      else n_pass++;
   endtask

   task automatic test_illegal(input logic [31:0] w);
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (got !== exp_step(w, k))
            $display("FAIL illegal ir=%h step=%0d got=%h expected=%h", w, k, got, exp_step(w, k));
         else
            n_pass++;
         if (k == 2) ir = w;
         @(posedge clk); @(negedge clk);
      end
      for (int i = 0; i < 4; i++) begin
         run = 1'($urandom_range(0, 1));
         ir  = rand_legal();
         n_checks++;
         if (got !== exp_step(w, 4)) $display("FAIL halt_hold cycle=%0d got=%h expected=%h", i, got, exp_step(w, 4));
         else n_pass++;
         @(posedge clk); @(negedge clk);
      end
      clr = 1'b1;
      #1;
      n_checks++;
      if (got !== out_t'(0)) $display("FAIL halt_clr got=%h expected=0", got);
      else n_pass++;
      run = 1'b1;
      #1 clr = 1'b0;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_random();
      logic [31:0] w;
      int          illegal_ops[$] = '{0, 1, 2, 19, 25, 31};
      for (int n = 0; n < 40; n++) begin
         w = rand_legal();
         exec_instr(w, 1'($urandom_range(0, 1)), 1'b1);
      end
      for (int n = 0; n < 3; n++) begin
         w = $urandom;
         w[31:27] = 5'(illegal_ops[$urandom_range(0, illegal_ops.size() - 1)]);
         test_illegal(w);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_clr_mid();
      test_illegal(32'h0000_0000);
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
